// File: rtl/mips_multicycle_control_pkg.sv
// mips_ctrl_defs: shared opcode/funct constants, FSM state encodings
// and datapath mux codes for the multi-cycle MIPS control unit.
package mips_ctrl_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_R_WB     = 4'd3,
        S_ADDI_EX  = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_LW_RD    = 4'd7,
        S_LW_WB    = 4'd8,
        S_SW_WR    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_ILLEGAL  = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_FUNCT = 3'b010;

    localparam logic [1:0] PCS_ULA    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: unified memory port request/ready bundle.
// master (control FSM): drives MemRead, MemWrite, IorD; samples mem_ready.
// slave (memory): samples the request, drives mem_ready on completion.
interface mips_multicycle_control_if;

    logic MemRead;
    logic MemWrite;
    logic IorD;
    logic mem_ready;

    modport master (
        output MemRead,
        output MemWrite,
        output IorD,
        input  mem_ready
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  IorD,
        output mem_ready
    );

endinterface

// File: rtl/mips_multicycle_control_decode.sv
// mips_mc_decode: combinational opcode/funct dispatch for the DECODE state.
// Ports: opcode_i, funct_i in; next_o (state after DECODE), illegal_o out.
module mips_mc_decode
    import mips_ctrl_defs::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output state_t     next_o,
    output logic       illegal_o
);

    always_comb begin
        next_o    = S_ILLEGAL;
        illegal_o = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                next_o    = (funct_i == FN_JR) ? S_JR : S_EXEC;
                illegal_o = 1'b0;
            end
            OP_LW, OP_SW: begin
                next_o    = S_MEM_ADDR;
                illegal_o = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                next_o    = S_BRANCH;
                illegal_o = 1'b0;
            end
            OP_ADDI: begin
                next_o    = S_ADDI_EX;
                illegal_o = 1'b0;
            end
            OP_J: begin
                next_o    = S_JUMP;
                illegal_o = 1'b0;
            end
            OP_JAL: begin
                next_o    = S_JAL;
                illegal_o = 1'b0;
            end
            default: begin
                next_o    = S_ILLEGAL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS control FSM (3-5 cycles/instr).
// Ports: clock, reset (async, active-low); opcode, funct, zero from datapath;
// mem (master modport: MemRead/MemWrite/IorD request, mem_ready reply);
// datapath mux/enable outputs, instr_done retire pulse, sticky illegal,
// state_dbg. Optional macro MIPS_MC_PERF_COUNT_EN adds cycle_cnt/instr_cnt.
module mips_multicycle_control
    import mips_ctrl_defs::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int PERF_W          = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    mips_multicycle_control_if.master mem,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic [1:0]  RegDst,
    output logic        isJAL,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ula_operation,
    output logic [1:0]  PCSource,
    output logic        branch_ne,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state_dbg
`ifdef MIPS_MC_PERF_COUNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    state_t state_q, state_d;
    state_t dec_next;
    logic   dec_illegal;
    logic   run_q;
    logic   illegal_q;
    logic   mem_read, mem_write, iord;

    // zero is qualified in the datapath through PCWriteCond/branch_ne.
    logic unused_zero;
    assign unused_zero = zero;

    mips_mc_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .next_o    (dec_next),
        .illegal_o (dec_illegal)
    );

    // run_q holds every output at 0 until the first edge after reset,
    // even though the state register already reads FETCH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (state_q == S_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = RD_RT;
        isJAL         = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REGB;
        ula_operation = ULA_ADD;
        PCSource      = PCS_ULA;
        branch_ne     = 1'b0;
        instr_done    = 1'b0;

        if (run_q) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    IRWrite  = mem.mem_ready;
                    PCWrite  = mem.mem_ready;
                    if (mem.mem_ready)
                        state_d = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH;
                    state_d = dec_illegal ? S_ILLEGAL : dec_next;
                end
                S_EXEC: begin
                    ALUSrcA       = 1'b1;
                    ula_operation = ULA_FUNCT;
                    state_d       = S_R_WB;
                end
                S_R_WB: begin
                    RegDst     = RD_RD;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    state_d = S_I_WB;
                end
                S_I_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    state_d = (opcode == OP_LW) ? S_LW_RD : S_SW_WR;
                end
                S_LW_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem.mem_ready)
                        state_d = S_LW_WB;
                end
                S_LW_WB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_SW_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem.mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ula_operation = ULA_SUB;
                    PCWriteCond   = 1'b1;
                    PCSource      = PCS_ALUOUT;
                    branch_ne     = (opcode == OP_BNE);
                    instr_done    = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCS_JUMP;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JAL: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCS_JUMP;
                    RegDst     = RD_RA;
                    isJAL      = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JR: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCS_REGA;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ILLEGAL: begin
                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign mem.MemRead  = mem_read;
    assign mem.MemWrite = mem_write;
    assign mem.IorD     = iord;

    // Flag is visible in the ILLEGAL cycle itself, then held by illegal_q.
    assign illegal   = illegal_q | (state_q == S_ILLEGAL);
    assign state_dbg = state_q;

`ifdef MIPS_MC_PERF_COUNT_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] instr_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT)
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (instr_done)
                instr_cnt_q <= instr_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle control FSM that sequences the existing MIPS datapath (PC, instruction/data memory, regfile, ULA) over 3-5 cycles per instruction, instead of the single-cycle combinational control.
- Shares one unified memory port between fetch and load/store through a req/ready handshake.
- Drives every datapath mux/enable, pulses per retired instruction, and flags illegal opcodes.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = park in HALT on an unknown opcode; 0 = treat it as a NOP and refetch.
- PERF_W, 32, width of the performance counters (only used with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ULA zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by the branch condition.
- IorD  out  1  memory address source: 0 = PC, 1 = ULA-out register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  regfile write data: 0 = ULA-out, 1 = MDR.
- RegDst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- isJAL  out  1  write PC+4 to the regfile.
- RegWrite  out  1  regfile write enable.
- ALUSrcA  out  1  ULA input A: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ULA input B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ula_operation  out  3  000 = add, 001 = sub, 010 = decode from funct.
- PCSource  out  2  00 = ULA result, 01 = ALUOut, 10 = jump target, 11 = register A (jr).
- branch_ne  out  1  invert the zero qualification for bne.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  sticky illegal-opcode flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: state = FETCH, all outputs 0, illegal = 0. The first FETCH outputs appear on the first edge after reset deasserts.
- Reset mid-instruction aborts immediately; a memory request in flight is dropped.
- Default output value in every state is 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ula_operation = add, PCSource = 00.
  - IRWrite = PCWrite = mem_ready (Mealy).
  - Stay in FETCH while mem_ready = 0. Go to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ula_operation = add (precomputes the branch target).
  - Dispatch on opcode:
    - 000000 → funct 001000 ? JR : EXEC.
    - 100011 or 101011 → MEM_ADDR.
    - 000100 or 000101 → BRANCH.
    - 001000 → ADDI_EX.
    - 000010 → JUMP.
    - 000011 → JAL.
    - Anything else → ILLEGAL.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ula_operation = 010. Next state R_WB.
- R_WB: RegDst = 01, RegWrite = 1, MemtoReg = 0. Retire.
- ADDI_EX: ALUSrcA = 1, ALUSrcB = 10, ula_operation = add. Next state I_WB.
- I_WB: RegDst = 00, RegWrite = 1. Retire.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ula_operation = add. Next state LW_RD if the opcode is lw, SW_WR if it is sw.
- LW_RD: MemRead = 1, IorD = 1. Hold until mem_ready, then go to LW_WB.
- LW_WB: RegDst = 00, MemtoReg = 1, RegWrite = 1. Retire.
- SW_WR: MemWrite = 1, IorD = 1. Hold until mem_ready. Retire in the mem_ready cycle.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ula_operation = sub, PCWriteCond = 1, PCSource = 01.
  - branch_ne = (opcode == 000101).
  - Retire.
- JUMP: PCWrite = 1, PCSource = 10. Retire.
- JAL: PCWrite = 1, PCSource = 10, RegDst = 10, isJAL = 1, RegWrite = 1. Retire.
- JR: PCWrite = 1, PCSource = 11. Retire.
- ILLEGAL:
  - Sets illegal = 1.
  - HALT_ON_ILLEGAL = 1 → HALT, an absorbing state with all enables 0 that only reset exits.
  - HALT_ON_ILLEGAL = 0 → FETCH, no retire pulse.
- Retire means: instr_done = 1 for that cycle, next state FETCH.
- MemRead and MemWrite are never asserted together. The request is held stable until mem_ready.
- A mem_ready seen in a state with no request is ignored.
- Latency with mem_ready tied to 1:
  - R-type, addi, lw-less: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne, j, jal, jr: 3 cycles.

Optional Feature:
- Macro MIPS_MC_PERF_COUNT_EN.
- When defined, adds output cycle_cnt[PERF_W] (increments every cycle out of reset, except in HALT) and output instr_cnt[PERF_W] (increments on instr_done).
- Both counters wrap modulo 2^PERF_W and reset to 0.
- When undefined, neither port nor counter logic exists.

Decomposition:
- Shared package/header mips_ctrl_defs:
  - Opcode and funct constants.
  - State encodings: FETCH = 0 … HALT = 15.
  - ula_operation codes, PCSource codes, RegDst codes.
- Natural sub-module: mips_mc_decode, combinational opcode/funct → next-state-after-DECODE plus the illegal flag. The FSM stays in the top.

Test Plan:
- Reset asserted mid-LW_RD with mem_ready = 0 → all outputs 0 at once; after release, FETCH with MemRead = 1, IorD = 0.
- add (opcode 0, funct 100000), mem_ready = 1 → states FETCH, DECODE, EXEC, R_WB; R_WB has RegWrite = 1, RegDst = 01; instr_done at cycle 4.
- lw with mem_ready low for 3 cycles in LW_RD → MemRead/IorD held stable; LW_WB one cycle after ready with MemtoReg = 1; no IRWrite outside FETCH.
- bne with zero = 0 → BRANCH with PCWriteCond = 1, branch_ne = 1, PCSource = 01; retires at cycle 3.
- jal then jr (funct 001000) → JAL: RegDst = 10, isJAL = 1, PCSource = 10. JR: PCSource = 11, RegWrite = 0.
- Opcode 111111, HALT_ON_ILLEGAL = 1 → illegal = 1 and state_dbg = 15 held for 20 cycles. With MIPS_MC_PERF_COUNT_EN defined, cycle_cnt frozen and instr_cnt unchanged.
